decode_stage: RTL and testbench

//  ID stage fed by the IF/ID buffer; sits between it and the ID/EX stage.

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: decode, 32x32 register file with write-first bypass, registered ID/EX bank
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [4:0]        dest_reg,
    output logic [2:0]        alu_op,
    output logic              alu_src,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              valid_out
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic [4:0] rd_addr;
    logic       unused_shamt;

    assign opcode       = instr_in[31:26];
    assign rs_addr      = instr_in[25:21];
    assign rt_addr      = instr_in[20:16];
    assign rd_addr      = instr_in[15:11];
    assign funct        = instr_in[5:0];
    assign unused_shamt = ^instr_in[10:6];

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we && wb_addr != 5'd0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Write-first: a same-cycle write-back wins over the stored value.
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;

    always_comb begin
        rs_rd = '0;
        if (rs_addr != 5'd0) begin
            if (wb_we && wb_addr == rs_addr) rs_rd = wb_data;
            else                             rs_rd = regs_q[rs_addr];
        end
    end

    always_comb begin
        rt_rd = '0;
        if (rt_addr != 5'd0) begin
            if (wb_we && wb_addr == rt_addr) rt_rd = wb_data;
            else                             rt_rd = regs_q[rt_addr];
        end
    end

    logic [2:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_reg_write;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_branch;
    logic [4:0] dec_dest;

    always_comb begin
        dec_alu_op    = 3'b000;
        dec_alu_src   = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_dest      = (opcode == OP_RTYPE) ? rd_addr : rt_addr;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin dec_alu_op = 3'b010; dec_reg_write = 1'b1; end
                    FN_SUB: begin dec_alu_op = 3'b110; dec_reg_write = 1'b1; end
                    FN_AND: begin dec_alu_op = 3'b000; dec_reg_write = 1'b1; end
                    FN_OR:  begin dec_alu_op = 3'b001; dec_reg_write = 1'b1; end
                    FN_SLT: begin dec_alu_op = 3'b111; dec_reg_write = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_alu_op    = 3'b010;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_LW: begin
                dec_alu_op    = 3'b010;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_SW: begin
                dec_alu_op    = 3'b010;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu_op = 3'b110;
                dec_branch = 1'b1;
            end
            default: ;
        endcase
    end

    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        dest_q, dest_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              alu_src_q, alu_src_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              branch_q, branch_d;
    logic              valid_q, valid_d;

    // Priority flush > stall > load; a flush leaves the data fields as they were.
    always_comb begin
        rs_d        = rs_q;
        rt_d        = rt_q;
        imm_d       = imm_q;
        dest_d      = dest_q;
        alu_op_d    = alu_op_q;
        alu_src_d   = alu_src_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;
        valid_d     = valid_q;
        if (flush) begin
            alu_op_d    = 3'b000;
            alu_src_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
            valid_d     = 1'b0;
        end else if (!stall) begin
            rs_d        = rs_rd;
            rt_d        = rt_rd;
            imm_d       = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
            dest_d      = dec_dest;
            alu_op_d    = instr_valid ? dec_alu_op : 3'b000;
            alu_src_d   = instr_valid & dec_alu_src;
            reg_write_d = instr_valid & dec_reg_write;
            mem_read_d  = instr_valid & dec_mem_read;
            mem_write_d = instr_valid & dec_mem_write;
            branch_d    = instr_valid & dec_branch;
            valid_d     = instr_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q        <= '0;
            rt_q        <= '0;
            imm_q       <= '0;
            dest_q      <= '0;
            alu_op_q    <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            imm_q       <= imm_d;
            dest_q      <= dest_d;
            alu_op_q    <= alu_op_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            valid_q     <= valid_d;
        end
    end

    assign rs_data   = rs_q;
    assign rt_data   = rt_q;
    assign imm_ext   = imm_q;
    assign dest_reg  = dest_q;
    assign alu_op    = alu_op_q;
    assign alu_src   = alu_src_q;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign branch    = branch_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic [4:0]  dest_reg;
    logic [2:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, branch, valid_out;

    int tests = 0;
    int fails = 0;

    decode_stage #(.DATA_W(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .dest_reg(dest_reg),
        .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        valid;
    } out_t;

    logic [31:0] model_regs [32];
    out_t        exp_out;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] w;
        w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
        return w;
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] w;
        w = {op, 5'(rs), 5'(rt), imm};
        return w;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'd0;
        if (wb_we && int'(wb_addr) == a) return wb_data;
        return model_regs[a];
    endfunction

    // Next ID/EX contents from the current inputs and the model's register file.
    function automatic out_t model_next(input out_t cur);
        out_t n;
        int op, fn;
        n  = cur;
        op = int'(instr_in[31:26]);
        fn = int'(instr_in[5:0]);
        if (flush) begin
            n.alu_op = 0; n.alu_src = 0; n.reg_write = 0;
            n.mem_read = 0; n.mem_write = 0; n.branch = 0; n.valid = 0;
            return n;
        end
        if (stall) return n;
        n.rs   = model_read(int'(instr_in[25:21]));
        n.rt   = model_read(int'(instr_in[20:16]));
        n.imm  = 32'(signed'(instr_in[15:0]));
        n.dest = (op == 0) ? instr_in[15:11] : instr_in[20:16];
        n.alu_op = 0; n.alu_src = 0; n.reg_write = 0;
        n.mem_read = 0; n.mem_write = 0; n.branch = 0;
        n.valid = instr_valid;
        if (instr_valid) begin
            if (op == 0) begin
                if (fn == 32) begin n.alu_op = 2; n.reg_write = 1; end
                if (fn == 34) begin n.alu_op = 6; n.reg_write = 1; end
                if (fn == 36) begin n.alu_op = 0; n.reg_write = 1; end
                if (fn == 37) begin n.alu_op = 1; n.reg_write = 1; end
                if (fn == 42) begin n.alu_op = 7; n.reg_write = 1; end
            end else if (op == 8 || op == 35) begin
                n.alu_op = 2; n.alu_src = 1; n.reg_write = 1; n.mem_read = (op == 35);
            end else if (op == 43) begin
                n.alu_op = 2; n.alu_src = 1; n.mem_write = 1;
            end else if (op == 4) begin
                n.alu_op = 6; n.branch = 1;
            end
        end
        return n;
    endfunction

    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                        input logic we, input int wa, input logic [31:0] wd);
        out_t nxt;
        instr_in = ins; instr_valid = v; stall = st; flush = fl;
        wb_we = we; wb_addr = 5'(wa); wb_data = wd;
        nxt = model_next(exp_out);
        @(posedge clk);
        if (!reset) begin
            exp_out = nxt;
            if (we && wa != 0) model_regs[wa] = wd;
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        out_t act;
        act = {rs_data, rt_data, imm_ext, dest_reg, alu_op, alu_src, reg_write,
               mem_read, mem_write, branch, valid_out};
        tests++;
        if (act !== exp_out) begin
            fails++;
            $display("FAIL model t=%0t: got %h, expected %h", $time, act, exp_out);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        exp_out = '0;
    endtask

    initial begin
        reset = 1'b1; instr_in = '0; instr_valid = 0; stall = 0; flush = 0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        step(rtype(5, 7, 3, 6'h20), 1, 0, 0, 0, 0, 0);
        chk("post_reset_rs", rs_data, 32'h0);
        chk("post_reset_rt", rt_data, 32'h0);

        step(32'h0, 0, 0, 0, 1, 5, 32'h12345678);
        step(32'h00A01820, 1, 0, 0, 0, 0, 0);
        chk("add_rs", rs_data, 32'h12345678);
        chk("add_rt", rt_data, 32'h0);
        chk("add_dest", 32'(dest_reg), 32'd3);
        chk("add_aluop", 32'(alu_op), 32'd2);
        chk("add_regwrite", 32'(reg_write), 32'd1);
        chk("add_valid", 32'(valid_out), 32'd1);

        step(32'h8CE8FFFC, 1, 0, 0, 1, 7, 32'hDEADBEEF);
        chk("lw_bypass_rs", rs_data, 32'hDEADBEEF);
        chk("lw_imm", imm_ext, 32'hFFFFFFFC);
        chk("lw_dest", 32'(dest_reg), 32'd8);
        chk("lw_memread", 32'(mem_read), 32'd1);
        chk("lw_alusrc", 32'(alu_src), 32'd1);

        step(32'h00001820, 1, 0, 0, 1, 0, 32'hFFFFFFFF);
        chk("r0_bypass_rs", rs_data, 32'h0);
        chk("r0_bypass_rt", rt_data, 32'h0);
        step(32'h00001820, 1, 0, 0, 0, 0, 0);
        chk("r0_read_rs", rs_data, 32'h0);

        step(rtype(5, 7, 9, 6'h22), 1, 0, 0, 0, 0, 0);
        chk("sub_aluop", 32'(alu_op), 32'd6);
        chk("sub_rt", rt_data, 32'hDEADBEEF);
        step(rtype(5, 7, 10, 6'h24), 1, 0, 0, 0, 0, 0);
        step(rtype(5, 7, 11, 6'h25), 1, 0, 0, 0, 0, 0);
        step(rtype(5, 7, 12, 6'h2A), 1, 0, 0, 0, 0, 0);
        chk("slt_aluop", 32'(alu_op), 32'd7);
        step(itype(6'h08, 5, 13, 16'h7FFF), 1, 0, 0, 0, 0, 0);
        chk("addi_imm", imm_ext, 32'h00007FFF);
        step(itype(6'h2B, 7, 5, 16'h0010), 1, 0, 0, 0, 0, 0);
        chk("sw_memwrite", 32'(mem_write), 32'd1);
        chk("sw_regwrite", 32'(reg_write), 32'd0);
        step(itype(6'h04, 5, 7, 16'hFFF0), 1, 0, 0, 0, 0, 0);
        chk("beq_branch", 32'(branch), 32'd1);
        step(rtype(5, 7, 3, 6'h21), 1, 0, 0, 0, 0, 0);
        chk("badfunct_regwrite", 32'(reg_write), 32'd0);
        step(32'h0, 1, 0, 0, 0, 0, 0);
        chk("nop_valid", 32'(valid_out), 32'd1);

        step(32'h00A01820, 1, 0, 0, 0, 0, 0);
        step(32'h8CE8FFFC, 1, 1, 0, 1, 5, 32'hCAFEF00D);
        step(itype(6'h2B, 1, 2, 16'h8000), 0, 1, 0, 0, 0, 0);
        step(itype(6'h04, 3, 4, 16'h1234), 1, 1, 0, 1, 6, 32'h1);
        chk("stall_rs", rs_data, 32'h12345678);
        chk("stall_dest", 32'(dest_reg), 32'd3);
        chk("stall_aluop", 32'(alu_op), 32'd2);
        chk("stall_valid", 32'(valid_out), 32'd1);
        step(32'h8CE8FFFC, 1, 1, 1, 0, 0, 0);
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_ctrl", {26'd0, alu_op, reg_write, mem_read, alu_src}, 32'd0);

        step(32'h00A01820, 0, 0, 0, 0, 0, 0);
        chk("invalid_valid", 32'(valid_out), 32'd0);
        chk("invalid_regwrite", 32'(reg_write), 32'd0);
        step({6'h3F, 5'd5, 5'd7, 16'h0}, 1, 0, 0, 0, 0, 0);
        chk("op3f_valid", 32'(valid_out), 32'd1);
        chk("op3f_ctrl", {26'd0, alu_op, alu_src, reg_write, mem_read}, 32'd0);
        step(32'h00A01820, 1, 0, 0, 0, 0, 0);
        chk("no_side_effect_rs", rs_data, 32'hCAFEF00D);

        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_valid", 32'(valid_out), 32'd0);
        chk("async_reset_rs", rs_data, 32'h0);
        chk("async_reset_regwrite", 32'(reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(rtype(5, 7, 3, 6'h20), 1, 0, 0, 0, 0, 0);
        chk("regfile_cleared_rs", rs_data, 32'h0);
        chk("regfile_cleared_rt", rt_data, 32'h0);
        step(32'h0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
